// File: rtl/quad_tick_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : quad_tick_counter_if
// Brief    : Encoder pins, control strobes and snapshot read port.
// Revision : 1.0
// ============================================================================
interface quad_tick_counter_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 8
);
    logic [N_CH-1:0]   enc_a;
    logic [N_CH-1:0]   enc_b;
    logic [1:0]        mode;
    logic [N_CH-1:0]   clear;
    logic              snap;
    logic              snap_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;

    modport master (
        output enc_a, enc_b, mode, clear, snap, rd_addr,
        input  snap_done, rd_data
    );

    modport slave (
        input  enc_a, enc_b, mode, clear, snap, rd_addr,
        output snap_done, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/quad_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : quad_tick_counter
// Brief    : Multi-channel debounced quadrature counter with snapshot read bank.
// Revision : 1.0
// ============================================================================
module quad_tick_counter #(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int ADDR_W      = 8
) (
    input wire clk,
    input wire reset,
    quad_tick_counter_if.slave bus
);
    localparam logic [1:0]  c_MODE_X1   = 2'b00;
    localparam logic [1:0]  c_MODE_X2   = 2'b01;
    localparam logic [1:0]  c_MODE_X4   = 2'b10;
    localparam logic [1:0]  c_MODE_HOLD = 2'b11;
    localparam logic [7:0]  c_DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [31:0] c_MAGIC     = 32'h0000_C0DE;

    logic [SYNC_STAGES-1:0][N_CH-1:0] r_syncA, r_syncB;
    logic [N_CH-1:0][7:0]             r_debA, r_debB;
    logic [N_CH-1:0]                  r_filtA, r_filtB, r_prevA, r_prevB;
    logic [N_CH-1:0]                  r_primed, r_dirLast;
    logic [7:0]                       r_primeCnt;
    logic [N_CH-1:0][CNT_W-1:0]       r_count, r_shadowCount;
    logic [N_CH-1:0][15:0]            r_err, r_shadowErr;
    logic                             r_snapDone;
    logic [31:0]                      r_rdData;

    logic [N_CH-1:0] w_syncA, w_syncB;
    logic [N_CH-1:0] w_chgA, w_chgB, w_fwdA, w_fwdB;
    logic [N_CH-1:0] w_inc, w_dec, w_dbl;
    logic            w_primeNow;
    logic [ADDR_W-3:0] w_chIdx;
    logic [31:0]     w_rdNext;

    // Returns {next filtered value, next stability counter}.
    function automatic logic [8:0] f_deb(input logic synced, input logic filt,
                                         input logic [7:0] cnt);
        if (synced == filt)          return {filt, 8'd0};
        else if (cnt == c_DEB_LAST)  return {synced, 8'd0};
        else                         return {filt, cnt + 8'd1};
    endfunction

    assign w_syncA    = r_syncA[SYNC_STAGES-1];
    assign w_syncB    = r_syncB[SYNC_STAGES-1];
    assign w_primeNow = (r_primeCnt == c_DEB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_syncA    <= '0;
            r_syncB    <= '0;
            r_debA     <= '0;
            r_debB     <= '0;
            r_filtA    <= '0;
            r_filtB    <= '0;
            r_prevA    <= '0;
            r_prevB    <= '0;
            r_primed   <= '0;
            r_primeCnt <= '0;
        end else begin
            r_syncA <= {r_syncA[SYNC_STAGES-2:0], bus.enc_a};
            r_syncB <= {r_syncB[SYNC_STAGES-2:0], bus.enc_b};
            if (!w_primeNow) begin
                r_primeCnt <= r_primeCnt + 8'd1;
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                if (!r_primed[ch]) begin
                    // First evaluation adopts the pin state as-is, so power-up levels never count.
                    if (w_primeNow) begin
                        r_filtA[ch]  <= w_syncA[ch];
                        r_filtB[ch]  <= w_syncB[ch];
                        r_prevA[ch]  <= w_syncA[ch];
                        r_prevB[ch]  <= w_syncB[ch];
                        r_primed[ch] <= 1'b1;
                    end
                end else begin
                    {r_filtA[ch], r_debA[ch]} <= f_deb(w_syncA[ch], r_filtA[ch], r_debA[ch]);
                    {r_filtB[ch], r_debB[ch]} <= f_deb(w_syncB[ch], r_filtB[ch], r_debB[ch]);
                    r_prevA[ch] <= r_filtA[ch];
                    r_prevB[ch] <= r_filtB[ch];
                end
            end
        end
    end

    // Forward order of {A,B} is 00->10->11->01: an A change is forward when new A differs
    // from B, a B change is forward when new B equals A.
    assign w_chgA = r_prevA ^ r_filtA;
    assign w_chgB = r_prevB ^ r_filtB;
    assign w_fwdA = r_filtA ^ r_prevB;
    assign w_fwdB = ~(r_filtB ^ r_prevA);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_dbl = '0;
        if (bus.mode != c_MODE_HOLD) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (r_primed[ch]) begin
                    if (w_chgA[ch] && w_chgB[ch]) begin
                        w_dbl[ch] = 1'b1;
                    end else if (w_chgA[ch] && (bus.mode == c_MODE_X2 || bus.mode == c_MODE_X4
                                 || (bus.mode == c_MODE_X1 && r_filtA[ch]))) begin
                        w_inc[ch] = w_fwdA[ch];
                        w_dec[ch] = ~w_fwdA[ch];
                    end else if (w_chgB[ch] && bus.mode == c_MODE_X4) begin
                        w_inc[ch] = w_fwdB[ch];
                        w_dec[ch] = ~w_fwdB[ch];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count       <= '0;
            r_err         <= '0;
            r_dirLast     <= '0;
            r_shadowCount <= '0;
            r_shadowErr   <= '0;
            r_snapDone    <= 1'b0;
        end else begin
            r_snapDone <= bus.snap;
            if (bus.snap) begin
                r_shadowCount <= r_count;
                r_shadowErr   <= r_err;
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                if (bus.clear[ch]) begin
                    r_count[ch] <= '0;
                    r_err[ch]   <= '0;
                end else begin
                    if (w_inc[ch])      r_count[ch] <= r_count[ch] + CNT_W'(1);
                    else if (w_dec[ch]) r_count[ch] <= r_count[ch] - CNT_W'(1);
                    if (w_dbl[ch] && r_err[ch] != 16'hFFFF) r_err[ch] <= r_err[ch] + 16'd1;
                end
                if (w_inc[ch] || w_dec[ch]) r_dirLast[ch] <= w_inc[ch];
            end
        end
    end

    assign w_chIdx = bus.rd_addr[ADDR_W-1:2];

    always_comb begin
        w_rdNext = 32'hFFFF_FFFF;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (int'(w_chIdx) == ch) begin
                case (bus.rd_addr[1:0])
                    2'd0:    w_rdNext = 32'(signed'(r_shadowCount[ch]));
                    2'd1:    w_rdNext = {16'd0, r_shadowErr[ch]};
                    2'd2:    w_rdNext = {29'd0, r_primed[ch], r_dirLast[ch],
                                         r_filtA[ch] ^ r_filtB[ch]};
                    default: w_rdNext = c_MAGIC;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_rdData <= '0;
        else       r_rdData <= w_rdNext;
    end

    assign bus.rd_data   = r_rdData;
    assign bus.snap_done = r_snapDone;
endmodule
`default_nettype wire

// File: tb/tb_quad_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_tick_counter
// Brief    : Directed and randomized checks of quad_tick_counter against a level-sequence model.
// Revision : 1.0
// ============================================================================
module tb_quad_tick_counter;
    logic clk = 1'b0;
    logic reset;
    int   nChecks = 0;
    int   nErrors = 0;

    always #5 clk = ~clk;

    quad_tick_counter_if #(.N_CH(2), .ADDR_W(8)) bus1();
    quad_tick_counter_if #(.N_CH(1), .ADDR_W(8)) bus2();

    quad_tick_counter #(.N_CH(2), .CNT_W(32), .SYNC_STAGES(2), .DEB_CYCLES(4), .ADDR_W(8))
        u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    quad_tick_counter #(.N_CH(1), .CNT_W(16), .SYNC_STAGES(2), .DEB_CYCLES(1), .ADDR_W(8))
        u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    // Model of channel state for u_dut1: applied {A,B} levels and resulting counts.
    logic [1:0]  lvl  [2];
    logic [31:0] mCnt [2];
    int          mErr [2];
    logic        mDir [2];
    logic [1:0]  curMode;
    logic [1:0]  lvl2;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Position of a level in the forward cycle 00,10,11,01.
    function automatic int posOf(input logic [1:0] v);
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) if (seq[i] == v) return i;
        return 0;
    endfunction

    function automatic logic [1:0] stepLvl(input logic [1:0] v, input int d);
        logic [1:0] seq [4];
        seq = '{2'b00, 2'b10, 2'b11, 2'b01};
        return seq[(posOf(v) + d + 4) % 4];
    endfunction

    task automatic modelStep(input int ch, input logic [1:0] nv);
        logic [1:0] ov;
        int d;
        ov = lvl[ch];
        lvl[ch] = nv;
        d = 0;
        if (curMode == 2'b11 || ov == nv) return;
        if (ov[1] != nv[1] && ov[0] != nv[0]) begin
            if (mErr[ch] < 65535) mErr[ch]++;
            return;
        end
        case (curMode)
            2'b10: d = ((posOf(nv) - posOf(ov) + 4) % 4 == 1) ? 1 : -1;
            2'b00: if (!ov[1] && nv[1]) d = nv[0] ? -1 : 1;
            2'b01: if (ov[1] != nv[1]) d = (nv[1] ^ nv[0]) ? 1 : -1;
            default: d = 0;
        endcase
        if (d != 0) begin
            mCnt[ch] = mCnt[ch] + 32'(d);
            mDir[ch] = (d > 0);
        end
    endtask

    task automatic drive1(input logic [1:0] v0, input logic [1:0] v1);
        bus1.enc_a = {v1[1], v0[1]};
        bus1.enc_b = {v1[0], v0[0]};
    endtask

    task automatic apply(input logic [1:0] v0, input logic [1:0] v1);
        drive1(v0, v1);
        modelStep(0, v0);
        modelStep(1, v1);
        tick(10);
    endtask

    task automatic setMode(input logic [1:0] m);
        bus1.mode = m;
        curMode = m;
    endtask

    task automatic clearCh(input int ch);
        bus1.clear[ch] = 1'b1;
        tick(1);
        bus1.clear = '0;
        mCnt[ch] = '0;
        mErr[ch] = 0;
    endtask

    task automatic snap1();
        bus1.snap = 1'b1;
        tick(1);
        check("snap_done_high", {31'd0, bus1.snap_done}, 32'd1);
        bus1.snap = 1'b0;
        tick(1);
        check("snap_done_low", {31'd0, bus1.snap_done}, 32'd0);
    endtask

    task automatic rd1(input logic [7:0] a, output logic [31:0] d);
        bus1.rd_addr = a;
        tick(1);
        d = bus1.rd_data;
    endtask

    task automatic rd2(input logic [7:0] a, output logic [31:0] d);
        bus2.rd_addr = a;
        tick(1);
        d = bus2.rd_data;
    endtask

    task automatic snap2();
        bus2.snap = 1'b1;
        tick(1);
        bus2.snap = 1'b0;
        tick(1);
    endtask

    task automatic checkAll();
        logic [31:0] d;
        snap1();
        for (int ch = 0; ch < 2; ch++) begin
            rd1(8'(ch * 4 + 0), d);
            check("count", d, mCnt[ch]);
            rd1(8'(ch * 4 + 1), d);
            check("errors", d, 32'(mErr[ch]));
            rd1(8'(ch * 4 + 2), d);
            check("status", d, {29'd0, 1'b1, mDir[ch], lvl[ch][1] ^ lvl[ch][0]});
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] oldCnt;
        logic [1:0]  nv0, nv1;

        reset = 1'b1;
        bus1.enc_a = '1; bus1.enc_b = '1; bus1.clear = '0; bus1.snap = 1'b0;
        bus1.rd_addr = 8'h02;
        setMode(2'b10);
        bus2.enc_a = '0; bus2.enc_b = '0; bus2.clear = '0; bus2.snap = 1'b0;
        bus2.mode = 2'b10; bus2.rd_addr = 8'h00;
        for (int ch = 0; ch < 2; ch++) begin
            lvl[ch] = 2'b11; mCnt[ch] = '0; mErr[ch] = 0; mDir[ch] = 1'b0;
        end
        lvl2 = 2'b00;

        tick(3);
        check("reset_rd_data", bus1.rd_data, 32'd0);
        check("reset_snap_done", {31'd0, bus1.snap_done}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("unprimed_status", bus1.rd_data, 32'd0);
        tick(10);
        checkAll();
        rd1(8'h02, d);  check("primed_status_11", d, 32'h0000_0004);
        rd1(8'h03, d);  check("magic", d, 32'h0000_C0DE);
        rd1(8'h08, d);  check("ch_out_of_range", d, 32'hFFFF_FFFF);

        // x4: eight forward then eight reverse steps on channel 0.
        for (int i = 0; i < 8; i++) apply(stepLvl(lvl[0], 1), lvl[1]);
        snap1(); rd1(8'h00, d); check("x4_fwd8", d, 32'd8);
        for (int i = 0; i < 8; i++) apply(stepLvl(lvl[0], -1), lvl[1]);
        checkAll();

        // x1 then x2 with four forward and two reverse full cycles.
        setMode(2'b00); clearCh(0);
        for (int i = 0; i < 16; i++) apply(stepLvl(lvl[0], 1), lvl[1]);
        for (int i = 0; i < 8; i++)  apply(stepLvl(lvl[0], -1), lvl[1]);
        snap1(); rd1(8'h00, d); check("x1_count", d, 32'd2);
        setMode(2'b01); clearCh(0);
        for (int i = 0; i < 16; i++) apply(stepLvl(lvl[0], 1), lvl[1]);
        for (int i = 0; i < 8; i++)  apply(stepLvl(lvl[0], -1), lvl[1]);
        snap1(); rd1(8'h00, d); check("x2_count", d, 32'd4);

        // Short glitch ignored; simultaneous A/B toggle is an error.
        setMode(2'b10);
        bus1.enc_a[0] = ~bus1.enc_a[0]; tick(3); bus1.enc_a[0] = ~bus1.enc_a[0]; tick(8);
        snap1(); rd1(8'h00, d); check("glitch_ignored", d, 32'd4);
        apply(~lvl[0], lvl[1]);
        snap1(); rd1(8'h01, d); check("double_toggle_err", d, 32'd1);
        rd1(8'h00, d); check("double_toggle_cnt", d, 32'd4);

        // Snap on the update edge (7th) sees the old count; on the 8th it sees the new one.
        oldCnt = mCnt[0];
        nv0 = stepLvl(lvl[0], 1);
        drive1(nv0, lvl[1]); tick(6);
        bus1.snap = 1'b1; tick(1); bus1.snap = 1'b0;
        check("snap_done_edge", {31'd0, bus1.snap_done}, 32'd1);
        modelStep(0, nv0); tick(3);
        rd1(8'h00, d); check("snap_on_edge_old", d, oldCnt);
        nv0 = stepLvl(lvl[0], 1);
        drive1(nv0, lvl[1]); tick(7);
        bus1.snap = 1'b1; tick(1); bus1.snap = 1'b0;
        modelStep(0, nv0); tick(3);
        rd1(8'h00, d); check("latency_after_edge", d, mCnt[0]);

        // Clear and snap together on the edge cycle: shadow pre-clear, live zeroed.
        oldCnt = mCnt[0];
        nv0 = stepLvl(lvl[0], 1);
        drive1(nv0, lvl[1]); tick(6);
        bus1.clear[0] = 1'b1; bus1.snap = 1'b1; tick(1);
        bus1.clear = '0; bus1.snap = 1'b0;
        modelStep(0, nv0); mCnt[0] = '0; mErr[0] = 0; tick(3);
        rd1(8'h00, d); check("snap_clear_old", d, oldCnt);
        checkAll();

        // Randomized mix of modes, steps, double toggles and sub-threshold glitches.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) setMode(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 4) == 0) begin
                bus1.enc_b[1] = ~bus1.enc_b[1]; tick($urandom_range(1, 3));
                bus1.enc_b[1] = ~bus1.enc_b[1]; tick(6);
            end
            case ($urandom_range(0, 9))
                0: nv0 = ~lvl[0];
                1, 2, 3, 4: nv0 = stepLvl(lvl[0], 1);
                5, 6, 7, 8: nv0 = stepLvl(lvl[0], -1);
                default: nv0 = lvl[0];
            endcase
            case ($urandom_range(0, 9))
                0: nv1 = ~lvl[1];
                1, 2, 3, 4, 5: nv1 = stepLvl(lvl[1], 1);
                6, 7, 8: nv1 = stepLvl(lvl[1], -1);
                default: nv1 = lvl[1];
            endcase
            apply(nv0, nv1);
            if (it % 6 == 5) checkAll();
        end

        // Reset mid-operation, with a filter decision pending.
        setMode(2'b10);
        nv0 = stepLvl(lvl[0], 1);
        drive1(nv0, lvl[1]); tick(3);
        reset = 1'b1; tick(1); reset = 1'b0;
        lvl[0] = nv0;
        for (int ch = 0; ch < 2; ch++) begin
            mCnt[ch] = '0; mErr[ch] = 0; mDir[ch] = 1'b0;
        end
        tick(10);
        checkAll();

        // 16-bit counter: wrap from max to min, clear on edge, decrement below zero.
        for (int i = 0; i < 32767; i++) begin
            lvl2 = stepLvl(lvl2, 1);
            bus2.enc_a = lvl2[1]; bus2.enc_b = lvl2[0];
            tick(1);
        end
        tick(6); snap2();
        rd2(8'h00, d); check("w16_max", d, 32'h0000_7FFF);
        lvl2 = stepLvl(lvl2, 1);
        bus2.enc_a = lvl2[1]; bus2.enc_b = lvl2[0];
        tick(6); snap2();
        rd2(8'h00, d); check("w16_wrap_min", d, 32'hFFFF_8000);
        lvl2 = stepLvl(lvl2, 1);
        bus2.enc_a = lvl2[1]; bus2.enc_b = lvl2[0];
        tick(3); bus2.clear = 1'b1; tick(1); bus2.clear = 1'b0;
        tick(4); snap2();
        rd2(8'h00, d); check("w16_clear_on_edge", d, 32'd0);
        lvl2 = stepLvl(lvl2, -1);
        bus2.enc_a = lvl2[1]; bus2.enc_b = lvl2[0];
        tick(6); snap2();
        rd2(8'h00, d); check("w16_below_zero", d, 32'hFFFF_FFFF);
        rd2(8'h02, d); check("w16_status", d, {29'd0, 1'b1, 1'b0, lvl2[1] ^ lvl2[0]});
        rd2(8'h04, d); check("w16_ch_out_of_range", d, 32'hFFFF_FFFF);
        rd2(8'h03, d); check("w16_magic", d, 32'h0000_C0DE);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/quad_tick_counter.md
Name: quad_tick_counter

Overview:
Parametrised multi-channel quadrature tick counter for the wheel encoders.
- Replaces per-edge free-running counters with synchronised, glitch-filtered, direction-aware counting.
- Counting mode is runtime-selectable: x1, x2 or x4.
- A snapshot bank is read by the SPI slave through a registered address-mapped read port.
- Sits between the encoder GPIO pins and the SPI Data_Addr/Data_Read interface.

Parameters:
N_CH, 2, number of encoder channels (A/B pairs), 1..16
CNT_W, 32, signed tick counter width, 16..32
SYNC_STAGES, 2, input synchroniser depth, >=2
DEB_CYCLES, 4, consecutive stable cycles required before a filtered input changes, 1..255
ADDR_W, 8, read address width

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
enc_a  in  N_CH  encoder A phases, asynchronous
enc_b  in  N_CH  encoder B phases, asynchronous
mode  in  2  00 x1 (rising A), 01 x2 (both A edges), 10 x4 (all A/B edges), 11 hold
clear  in  N_CH  per-channel count/error clear, one-cycle pulse
snap  in  1  latch all live counts/errors into the shadow bank
snap_done  out  1  one-cycle pulse, the cycle after snap
rd_addr  in  ADDR_W  read address from the SPI slave
rd_data  out  32  registered read data

Behaviour:
- Reset (synchronous):
  - Zeroes all synchroniser flops, filter counters, filtered A/B, live counts, shadow counts, error counters, shadows and dir_last.
  - Clears the per-channel primed flag.
  - Drives rd_data=0 and snap_done=0.
- Synchroniser: SYNC_STAGES flops per input.
- Filter:
  - Per input, a counter increments while the synced value differs from the filtered value and resets to 0 when they match.
  - When the counter reaches DEB_CYCLES, filtered takes the synced value.
  - Pulses shorter than DEB_CYCLES cycles are ignored.
- Priming:
  - After reset, a channel is unprimed.
  - Its first filter evaluation (DEB_CYCLES cycles after reset release) loads filtered A/B directly from the synced values and sets primed.
  - No count and no error occur on priming.
- Edge decode: on each primed cycle, compare prev {A,B} with the new filtered {A,B}.
  - Forward sequence (A leads B) is 00->10->11->01->00 = +1; the reverse is -1.
  - x1: count only on rising A; +1 if B=0, else -1.
  - x2: count on any A edge; +1 if (A^B)=1 after the edge, else -1.
  - x4: every single-bit transition counts per the table.
  - Both bits changing in one cycle: no count; the error counter increments in all modes except hold.
  - Hold: no counting and no errors; prev still tracks the filtered value.
- Counts:
  - Two's complement, wrap modulo 2^CNT_W (max+1 -> min, 0-1 -> all ones).
  - Sign-extended to 32 bits on read.
- Error counters: 16-bit, saturate at 0xFFFF, zero-extended on read.
- Latency: a clean input edge changes the live count exactly SYNC_STAGES+DEB_CYCLES+1 clk edges after first sampling (7 with defaults).
- Simultaneous events:
  - clear together with an edge: count=0 and error=0 (clear wins).
  - snap together with an edge: shadow captures the pre-update value.
  - snap together with clear: shadow captures the pre-clear value.
- Mode change takes effect on the next cycle; filtered and prev state are kept.
- Read port:
  - rd_data <= mux(rd_addr) every cycle, 1-cycle latency.
  - Address decode: ch = rd_addr[ADDR_W-1:2], sel = rd_addr[1:0].
  - sel 0: shadow count. sel 1: shadow error. sel 2: status {29'b0, primed, dir_last, filtered_A^filtered_B}. sel 3: 0x0000_C0DE.
  - dir_last = 1 if the last counted step was +1 (reset 0).
  - ch >= N_CH returns 0xFFFF_FFFF.
- Reset mid-operation: everything returns to reset values next cycle, including pending filter progress; the channel re-primes.

Test Plan:
1. Reset, then hold A=B=1 for 10 cycles -> primed=1, count=0, error=0; rd_addr=0x02 returns 0x4 after snap.
2. mode=10, drive 8 forward quadrature steps, 10 cycles each -> snap, rd_addr=0x00 returns 8; 8 reverse steps -> 0.
3. mode=00, 4 forward full cycles then 2 reverse -> count=2; mode=01 with same stimulus -> 4.
4. 3-cycle glitch on A with DEB_CYCLES=4 -> count unchanged; A and B toggled in the same cycle in mode 10 -> error=1, count unchanged.
5. CNT_W=16, preload via 32767 forward x4 steps, then 1 more -> read 0xFFFF_8000; clear pulsed on the same cycle as an edge -> 0.
6. snap asserted on the edge cycle -> shadow holds the old value, snap_done high next cycle; rd_addr=0x08 with N_CH=2 -> 0xFFFF_FFFF; rd_addr=0x03 -> 0x0000_C0DE.
